vend_payout_ctrl: RTL

- Actuator-side controller that consumes the one-cycle vend result produced by the vending FSM (product_dispensed, product_select, change).
- Drives the product motor for the selected slot, then drives the coin hopper to pay change as Rs 5 coins, one at a time.
- Uses handshake and timeout supervision on both actuators; latches faults until cleared.
- Sits between the vending FSM and the physical motor/hopper drivers.

---
 rtl/vend_payout_ctrl_pkg.sv | 65 ++++++
 rtl/vend_payout_ctrl_cycle_timer.sv | 36 +++
 rtl/vend_payout_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/vend_payout_ctrl_pkg.sv
// Shared definitions for the vend payout controller and the vending FSM.
// Contents:
//   - product slot codes
//   - change-unit value
//   - payout state encoding
//   - fault codes
//   - latched request payload
//   - small helper functions
package vend_payout_ctrl_pkg;

    localparam int unsigned SEL_W   = 2;
    localparam int unsigned CHG_W   = 2;
    localparam int unsigned FCODE_W = 2;

    // Product slot codes, shared with the vending FSM.
    localparam logic [SEL_W-1:0] P_NONE = 2'b00;
    localparam logic [SEL_W-1:0] P_RS5  = 2'b01;
    localparam logic [SEL_W-1:0] P_RS10 = 2'b10;
    localparam logic [SEL_W-1:0] P_RS15 = 2'b11;

    // Value of one hopper coin in rupees; change is counted in these units.
    localparam int unsigned COIN_RS = 5;

    localparam logic [FCODE_W-1:0] FC_NONE  = 2'b00;
    localparam logic [FCODE_W-1:0] FC_MOTOR = 2'b01;
    localparam logic [FCODE_W-1:0] FC_COIN  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_VEND      = 3'd1,
        ST_PAY_PULSE = 3'd2,
        ST_PAY_WAIT  = 3'd3,
        ST_DONE      = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    // Request captured when a vend strobe is accepted; coins counts down during payout.
    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic [CHG_W-1:0] coins;
    } vend_req_t;

    function automatic logic is_product(input logic [SEL_W-1:0] sel);
        return (sel == P_RS5) || (sel == P_RS10) || (sel == P_RS15);
    endfunction

    // Rupee value of a change code (0..15).
    function automatic logic [3:0] change_value_rs(input logic [CHG_W-1:0] coins);
        return 4'(int'(coins) * COIN_RS);
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Shared timer width, wide enough for the largest limit plus saturation headroom.
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                                input int unsigned c);
        return $clog2(max3(a, b, c)) + 1;
    endfunction

endpackage

// File: rtl/vend_payout_ctrl_cycle_timer.sv
// Saturating up-counter with synchronous clear and enable.
// The terminal compare flags when the current count has reached 'last'.
// Ports:
//   clk    - system clock
//   rst    - synchronous active-low reset
//   clr    - synchronous clear to zero; has priority over en
//   en     - count enable
//   last   - terminal value to compare against
//   hit_c  - combinational, count >= last
module cycle_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic         hit_c
);

    logic [W-1:0] count_q;

    // Counter register; holds at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign hit_c = (count_q >= last);

endmodule

// File: rtl/vend_payout_ctrl.sv
// Actuator-side payout controller. It takes the one-cycle vend result from the
// vending FSM, runs the product motor for the selected slot, then pays the
// change as Rs 5 coins one at a time through the hopper. Both actuators are
// supervised by timeouts, and faults latch until fault_clr.
// Ports:
//   clk, rst            - clock, synchronous active-low reset
//   product_dispensed   - vend request strobe (one cycle)
//   product_select      - product slot code
//   change              - coins owed (0..3)
//   motor_done          - product-drop sensor (level)
//   coin_sensed         - hopper exit sensor (one cycle per coin)
//   fault_clr           - clears a latched fault and req_overrun
//   motor_en, motor_sel - product motor drive and slot
//   coin_eject          - hopper eject drive
//   busy                - high whenever not idle
//   vend_done           - one-cycle completion pulse
//   fault, fault_code   - latched fault indication and cause
//   req_overrun         - sticky, a request arrived while busy
module vend_payout_ctrl
    import vend_payout_ctrl_pkg::*;
#(
    parameter int unsigned MOTOR_TIMEOUT = 1000,
    parameter int unsigned EJECT_PULSE   = 4,
    parameter int unsigned COIN_TIMEOUT  = 200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               product_dispensed,
    input  logic [SEL_W-1:0]   product_select,
    input  logic [CHG_W-1:0]   change,
    input  logic               motor_done,
    input  logic               coin_sensed,
    input  logic               fault_clr,
    output logic               motor_en,
    output logic [SEL_W-1:0]   motor_sel,
    output logic               coin_eject,
    output logic               busy,
    output logic               vend_done,
    output logic               fault,
    output logic [FCODE_W-1:0] fault_code,
    output logic               req_overrun
);

    localparam int unsigned TW = timer_width(MOTOR_TIMEOUT, COIN_TIMEOUT, EJECT_PULSE);

    // The timer is zero in the first cycle of a state, so the last permitted
    // cycle of an N-cycle window is reached when the count equals N-1.
    localparam logic [TW-1:0] MOTOR_LAST = TW'(MOTOR_TIMEOUT - 1);
    localparam logic [TW-1:0] EJECT_LAST = TW'(EJECT_PULSE - 1);
    localparam logic [TW-1:0] COIN_LAST  = TW'(COIN_TIMEOUT - 1);

    state_t    state_q;
    state_t    state_d;
    vend_req_t req_q;
    vend_req_t req_d;

    logic               motor_en_d;
    logic               coin_eject_d;
    logic               busy_d;
    logic               vend_done_d;
    logic               fault_d;
    logic [FCODE_W-1:0] fault_code_d;
    logic               req_overrun_d;

    logic          tmr_clr;
    logic          tmr_en;
    logic          tmr_hit;
    logic [TW-1:0] tmr_last;

    // One timer shared by all supervised states; it restarts on every state change.
    cycle_timer #(
        .W (TW)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .last  (tmr_last),
        .hit_c (tmr_hit)
    );

    // Timer window for the current state.
    always_comb begin
        tmr_last = '1;
        tmr_en   = 1'b0;
        case (state_q)
            ST_VEND: begin
                tmr_last = MOTOR_LAST;
                tmr_en   = 1'b1;
            end
            ST_PAY_PULSE: begin
                tmr_last = EJECT_LAST;
                tmr_en   = 1'b1;
            end
            ST_PAY_WAIT: begin
                tmr_last = COIN_LAST;
                tmr_en   = 1'b1;
            end
            default: begin
                tmr_last = '1;
                tmr_en   = 1'b0;
            end
        endcase
    end

    // Next state and request update. Sensor events are checked before the
    // timeout, so a completion in the final allowed cycle still counts.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        case (state_q)
            ST_IDLE: begin
                if (product_dispensed && is_product(product_select)) begin
                    state_d     = ST_VEND;
                    req_d.sel   = product_select;
                    req_d.coins = change;
                end
            end
            ST_VEND: begin
                if (motor_done) begin
                    state_d = (req_q.coins != '0) ? ST_PAY_PULSE : ST_DONE;
                end else if (tmr_hit) begin
                    state_d = ST_FAULT;
                end
            end
            ST_PAY_PULSE: begin
                if (tmr_hit) begin
                    state_d = ST_PAY_WAIT;
                end
            end
            ST_PAY_WAIT: begin
                if (coin_sensed) begin
                    req_d.coins = req_q.coins - CHG_W'(1);
                    state_d     = (req_q.coins == CHG_W'(1)) ? ST_DONE : ST_PAY_PULSE;
                end else if (tmr_hit) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                req_d   = '0;
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    state_d = ST_IDLE;
                    req_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = '0;
            end
        endcase
    end

    assign tmr_clr = (state_d != state_q);

    // Output values for the coming cycle, decoded from the next state.
    always_comb begin
        motor_en_d    = (state_d == ST_VEND);
        coin_eject_d  = (state_d == ST_PAY_PULSE);
        busy_d        = (state_d != ST_IDLE);
        vend_done_d   = (state_d == ST_DONE);
        fault_d       = (state_d == ST_FAULT);
        fault_code_d  = FC_NONE;
        req_overrun_d = req_overrun;

        if (state_d == ST_FAULT) begin
            if (state_q == ST_FAULT) begin
                fault_code_d = fault_code;
            end else begin
                fault_code_d = (state_q == ST_VEND) ? FC_MOTOR : FC_COIN;
            end
        end

        // A fresh overrun in the same cycle as a clear is kept.
        if (product_dispensed && (state_q != ST_IDLE)) begin
            req_overrun_d = 1'b1;
        end else if (fault_clr) begin
            req_overrun_d = 1'b0;
        end
    end

    // State, request and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            motor_en    <= 1'b0;
            motor_sel   <= '0;
            coin_eject  <= 1'b0;
            busy        <= 1'b0;
            vend_done   <= 1'b0;
            fault       <= 1'b0;
            fault_code  <= FC_NONE;
            req_overrun <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            motor_en    <= motor_en_d;
            motor_sel   <= req_d.sel;
            coin_eject  <= coin_eject_d;
            busy        <= busy_d;
            vend_done   <= vend_done_d;
            fault       <= fault_d;
            fault_code  <= fault_code_d;
            req_overrun <= req_overrun_d;
        end
    end

endmodule
